// File: rtl/fuzzy_irrigation_seq.sv
// Sequential Sugeno fuzzy irrigation engine: latch a sample, fuzzify, accumulate 18 min-rules
// one per cycle, then form the weighted mean with a bit-serial restoring divider.

module fuzzy_irrigation_seq_mf #(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0]      x,
    input  logic [DATA_WIDTH-1:0]      lo,
    input  logic [DATA_WIDTH-1:0]      mid,
    input  logic [DATA_WIDTH-1:0]      hi,
    output logic [2:0][DATA_WIDTH-1:0] mu
);
    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic [W2-1:0] MU_MAX_W = {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}};

    logic [DATA_WIDTH-1:0] a, b, span, mf, mr;
    logic [W2-1:0]         qf, qr;

    // Active segment is (lo,mid] or (mid,hi]; shared falling/rising ramps over it.
    always_comb begin
        a = lo;
        b = mid;
        if (x > mid) begin
            a = mid;
            b = hi;
        end
    end

    // Span is never zero when a segment is actually reached; the guard only keeps
    // the unused divide well defined.
    assign span = (b == a) ? DATA_WIDTH'(1) : b - a;
    assign qf = ({{DATA_WIDTH{1'b0}}, b - x} * MU_MAX_W) / {{DATA_WIDTH{1'b0}}, span};
    assign qr = ({{DATA_WIDTH{1'b0}}, x - a} * MU_MAX_W) / {{DATA_WIDTH{1'b0}}, span};
    assign mf = (|qf[W2-1:DATA_WIDTH]) ? '1 : qf[DATA_WIDTH-1:0];
    assign mr = (|qr[W2-1:DATA_WIDTH]) ? '1 : qr[DATA_WIDTH-1:0];

    always_comb begin
        mu = '0;
        if (x <= lo) begin
            mu[0] = '1;
        end else if (x <= mid) begin
            mu[0] = mf;
            mu[1] = mr;
        end else if (x <= hi) begin
            mu[1] = mf;
            mu[2] = mr;
        end else begin
            mu[2] = '1;
        end
    end
endmodule

module fuzzy_irrigation_seq #(
    parameter int DATA_WIDTH    = 10,
    parameter int OUT_WIDTH     = 8,
    parameter int RAIN_OVERRIDE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] soil_in,
    input  logic [DATA_WIDTH-1:0] temp_in,
    input  logic [DATA_WIDTH-1:0] rain_in,
    input  logic                  cfg_we,
    input  logic [4:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_WIDTH-1:0]  irrigation_time,
    output logic                  rain_present,
    output logic                  cfg_err
);
    localparam int NUM_W  = DATA_WIDTH + OUT_WIDTH + 5;
    localparam int DEN_W  = DATA_WIDTH + 5;
    localparam int NRULES = 18;
    localparam logic [7:0][DATA_WIDTH-1:0] TH_RST = {
        DATA_WIDTH'(400), DATA_WIDTH'(100),                   // rain yes, no
        DATA_WIDTH'(700), DATA_WIDTH'(500), DATA_WIDTH'(300), // temp hot, warm, cold
        DATA_WIDTH'(800), DATA_WIDTH'(600), DATA_WIDTH'(400)  // soil wet, moist, dry
    };

    typedef enum logic [2:0] {IDLE, FUZZ, RULE, DIV, DONE} state_t;

    function automatic logic [NRULES-1:0][OUT_WIDTH-1:0] cq_reset();
        logic [NRULES-1:0][OUT_WIDTH-1:0] v;
        v     = '0;
        v[2]  = OUT_WIDTH'(10);
        v[8]  = OUT_WIDTH'(10);
        v[14] = OUT_WIDTH'(10);
        v[4]  = OUT_WIDTH'(45);
        v[10] = OUT_WIDTH'(45);
        v[16] = OUT_WIDTH'(30);
        return v;
    endfunction

    state_t                           state;
    logic [7:0][DATA_WIDTH-1:0]       th;
    logic [NRULES-1:0][OUT_WIDTH-1:0] cq;
    logic [2:0][DATA_WIDTH-1:0]       smp;
    logic [2:0][2:0][DATA_WIDTH-1:0]  mu_c;
    logic [2:0][DATA_WIDTH-1:0]       mu_s, mu_t;
    logic [1:0][DATA_WIDTH-1:0]       mu_r;
    logic                             rain_flag;
    logic [1:0]                       s_i, t_i;
    logic                             r_i;
    logic [4:0]                       cnt;
    logic [NUM_W-1:0]                 num, num_nx, rem, dsh;
    logic [DEN_W-1:0]                 den, den_nx;
    logic                             den_zero;
    logic [OUT_WIDTH-2:0]             quo;

    // Rain has only no/yes: hi = mid collapses the upper ramp, so "yes" is the
    // rising ramp on (no,yes] or full membership above yes.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_mf
            localparam int HI = (g == 2) ? 7 : 3 * g + 2;
            fuzzy_irrigation_seq_mf #(.DATA_WIDTH(DATA_WIDTH)) u_mf (
                .x  (smp[g]),
                .lo (th[3*g]),
                .mid(th[3*g+1]),
                .hi (th[HI]),
                .mu (mu_c[g])
            );
        end
    endgenerate

    logic [DATA_WIDTH-1:0]           m_st, str;
    logic [DATA_WIDTH+OUT_WIDTH-1:0] prod;
    logic                            ge;
    logic [OUT_WIDTH-1:0]            q_final;
    logic                            cfg_ok;
    logic [4:0]                      cq_idx;

    always_comb begin
        m_st = (mu_s[s_i] < mu_t[t_i]) ? mu_s[s_i] : mu_t[t_i];
        str  = (m_st < mu_r[r_i]) ? m_st : mu_r[r_i];
    end

    assign prod    = {{OUT_WIDTH{1'b0}}, str} * {{DATA_WIDTH{1'b0}}, cq[cnt]};
    assign num_nx  = num + {5'b0, prod};
    assign den_nx  = den + {5'b0, str};
    assign ge      = !den_zero && (rem >= dsh);
    assign q_final = {quo, ge};
    assign cfg_ok  = cfg_we && (state == IDLE) && (cfg_addr <= 5'd25);
    assign cq_idx  = cfg_addr - 5'd8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            th              <= TH_RST;
            cq              <= cq_reset();
            smp             <= '0;
            mu_s            <= '0;
            mu_t            <= '0;
            mu_r            <= '0;
            rain_flag       <= 1'b0;
            s_i             <= '0;
            t_i             <= '0;
            r_i             <= 1'b0;
            cnt             <= '0;
            num             <= '0;
            den             <= '0;
            rem             <= '0;
            dsh             <= '0;
            den_zero        <= 1'b0;
            quo             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            irrigation_time <= '0;
            rain_present    <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                if (cfg_addr[4:3] == 2'b00) th[cfg_addr[2:0]] <= cfg_data;
                else                        cq[cq_idx]        <= cfg_data[OUT_WIDTH-1:0];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        smp   <= {rain_in, temp_in, soil_in};
                        num   <= '0;
                        den   <= '0;
                        busy  <= 1'b1;
                        state <= FUZZ;
                    end
                end
                FUZZ: begin
                    mu_s      <= mu_c[0];
                    mu_t      <= mu_c[1];
                    mu_r      <= {mu_c[2][1] | mu_c[2][2], mu_c[2][0]};
                    rain_flag <= smp[2] >= th[7];
                    s_i       <= '0;
                    t_i       <= '0;
                    r_i       <= 1'b0;
                    cnt       <= '0;
                    state     <= RULE;
                end
                RULE: begin
                    num <= num_nx;
                    den <= den_nx;
                    cnt <= cnt + 5'd1;
                    // Odometer over (s,t,r) keeps k = 6s + 2t + r without a divide.
                    if (r_i) begin
                        r_i <= 1'b0;
                        if (t_i == 2'd2) begin
                            t_i <= '0;
                            s_i <= s_i + 2'd1;
                        end else begin
                            t_i <= t_i + 2'd1;
                        end
                    end else begin
                        r_i <= 1'b1;
                    end
                    if (cnt == 5'(NRULES - 1)) begin
                        cnt      <= '0;
                        rem      <= num_nx;
                        dsh      <= {1'b0, den_nx, {(OUT_WIDTH-1){1'b0}}};
                        den_zero <= (den_nx == '0);
                        quo      <= '0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    // Weighted mean never exceeds the largest consequent, so the
                    // quotient fits OUT_WIDTH bits with the divisor pre-shifted.
                    if (ge) rem <= rem - dsh;
                    dsh <= dsh >> 1;
                    quo <= {quo[OUT_WIDTH-3:0], ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(OUT_WIDTH - 1)) begin
                        irrigation_time <= (RAIN_OVERRIDE != 0 && rain_flag) ? '0 : q_final;
                        rain_present    <= rain_flag;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
